data_ram_arbiter: RTL and testbench
===================================

Name: data_ram_arbiter

Overview:
- Sequences and shares the single-port 1-bit data RAM (with memory-mapped I/O pins) between two requesters: the ICU core (CPU port) and a host/debug port.
- Generates the RAM's edge-triggered write strobe with correct address/data setup and read sampling.
- Provides a full-memory clear sweep using the RAM's reset-on-write function.
- Sits between the ICU control logic and the data RAM. All RAM-side signals originate here.

Parameters:
- WORD, 1, data width of RAM word and of both requester data paths.
- SIZE_LOG, 8, RAM address width. The RAM has 2**SIZE_LOG locations.
- HOST_MAX_WAIT, 4, number of consecutive lost arbitrations after which host_req is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU access request, level, held until cpu_ack.
- cpu_write  in  1  1 = write, 0 = read. Stable while cpu_req is high.
- cpu_addr  in  SIZE_LOG  CPU address.
- cpu_wdata  in  WORD  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  WORD  read data, valid while cpu_ack is high, held afterwards.
- host_req, host_write, host_addr, host_wdata, host_ack, host_rdata: same meaning and widths as the CPU set.
- clear_start  in  1  one-cycle pulse requesting a sweep that zeroes every RAM location.
- clear_busy  out  1  high while the sweep runs.
- ram_write  out  1  RAM write strobe (RAM writes on its rising edge).
- ram_reset  out  1  RAM reset input (a write with ram_reset high clears the addressed location).
- ram_address  out  SIZE_LOG  RAM address.
- ram_data_in  out  WORD  RAM write data.
- ram_data_out  in  WORD  RAM read data (transparent while ram_write is low).

Behaviour:
- All outputs are registered.
- Reset values:
  - FSM state IDLE.
  - ram_write, ram_reset, cpu_ack, host_ack, clear_busy = 0.
  - ram_address, ram_data_in, cpu_rdata, host_rdata = 0.
  - Host wait counter = 0.
  - Clear index = 0.
- FSM states: IDLE, SETUP, STROBE, ACK, CLR_SETUP, CLR_STROBE, CLR_END.
- IDLE decision, in priority order:
  - clear_start → CLR_SETUP.
  - Else, if host_req is high and the wait counter equals HOST_MAX_WAIT → grant host.
  - Else, cpu_req → grant CPU.
  - Else, host_req → grant host.
  - Else, stay in IDLE.
- On a grant, the latched owner's addr/wdata/write drive ram_address/ram_data_in, and the FSM moves to SETUP.
- Wait counter:
  - Increments (saturating at HOST_MAX_WAIT) when CPU is granted while host_req is high.
  - Clears on a host grant or whenever host_req is low in IDLE.
- SETUP:
  - ram_write = 0, address and data stable.
  - If write → STROBE.
  - If read → ACK, capturing ram_data_out into the owner's rdata on the same edge.
- STROBE: ram_write = 1 for exactly one cycle → ACK.
- ACK:
  - ram_write = 0, owner's ack = 1 for one cycle → IDLE.
  - The non-owner's ack stays 0.
- Latency, counted from the IDLE cycle in which the request is sampled:
  - Write: ack 3 cycles later.
  - Read: ack 2 cycles later.
  - Minimum back-to-back period: 4 cycles per write, 3 per read.
- Requester contract:
  - The requester drops req on the edge at which it sees ack high.
  - req still high in the cycle after ACK is treated as a new request.
- ram_address and ram_data_in hold their last value in IDLE. ram_write is never high in two consecutive cycles.
- Clear sweep:
  - clear_busy = 1 from the CLR_SETUP entry through CLR_END.
  - CLR_SETUP: ram_reset = 1, ram_write = 0, ram_address = index.
  - CLR_STROBE: ram_reset = 1, ram_write = 1.
  - After CLR_STROBE: if index == 2**SIZE_LOG − 1 → CLR_END; else index+1 and return to CLR_SETUP.
  - CLR_END: ram_write = 0, ram_reset = 1 → IDLE, where ram_reset = 0 and index = 0.
  - Sweep duration: 2·2**SIZE_LOG + 1 cycles.
- clear_start outside IDLE is ignored (not queued). Requests pending during a sweep stay pending and are arbitrated in IDLE afterwards.
- Reset mid-operation:
  - Next state is IDLE with all outputs at reset values; no ack is issued for the aborted access.
  - A write already strobed (STROBE reached) is complete in RAM.
  - A sweep aborted by reset leaves a partially cleared RAM.

Test Plan:
- CPU write addr 0x20 data 1, then CPU read 0x20 → ram_write high exactly in cycle 2; cpu_ack in cycle 3; read ack 2 cycles after its IDLE; cpu_rdata = 1.
- Host read of input-pin address 5 with the pin model driving 1 → host_rdata = 1 at host_ack; ram_write stays 0 throughout; cpu_ack never pulses.
- cpu_req held continuously with back-to-back reads, host_req high from cycle 0, HOST_MAX_WAIT = 4 → host granted after exactly 4 CPU grants; counter then clears.
- Simultaneous cpu_req and host_req with wait counter 0 → CPU served first, host served next; each ack a single cycle.
- Preload addresses 0x10 and 0xFF with 1, pulse clear_start → clear_busy high for 513 cycles; ram_reset high with every strobe; subsequent reads of 0x10 and 0xFF return 0.
- Assert reset in the SETUP cycle of a CPU write → no ram_write pulse, no cpu_ack; memory at the target address unchanged; a fresh request completes normally afterwards.

Source files
------------

// File: rtl/data_ram_arbiter_if.sv
// Requester, clear-control and data-RAM signal bundle for data_ram_arbiter.
// slave is the arbiter's view; master is the ICU/host/RAM environment's view.
interface data_ram_arbiter_if #(
  parameter int unsigned WORD     = 1,
  parameter int unsigned SIZE_LOG = 8
);
  logic                cpu_req;
  logic                cpu_write;
  logic [SIZE_LOG-1:0] cpu_addr;
  logic [WORD-1:0]     cpu_wdata;
  logic                cpu_ack;
  logic [WORD-1:0]     cpu_rdata;

  logic                host_req;
  logic                host_write;
  logic [SIZE_LOG-1:0] host_addr;
  logic [WORD-1:0]     host_wdata;
  logic                host_ack;
  logic [WORD-1:0]     host_rdata;

  logic                clear_start;
  logic                clear_busy;

  logic                ram_write;
  logic                ram_reset;
  logic [SIZE_LOG-1:0] ram_address;
  logic [WORD-1:0]     ram_data_in;
  logic [WORD-1:0]     ram_data_out;

  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  host_req, host_write, host_addr, host_wdata,
    output host_ack, host_rdata,
    input  clear_start,
    output clear_busy,
    output ram_write, ram_reset, ram_address, ram_data_in,
    input  ram_data_out
  );

  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output host_req, host_write, host_addr, host_wdata,
    input  host_ack, host_rdata,
    output clear_start,
    input  clear_busy,
    input  ram_write, ram_reset, ram_address, ram_data_in,
    output ram_data_out
  );
endinterface

// File: rtl/data_ram_arbiter.sv
// Shares the single-port 1-bit data RAM between the ICU core and the host port,
// generating the edge-triggered write strobe and a full-memory clear sweep.
module data_ram_arbiter #(
  parameter int unsigned WORD          = 1,
  parameter int unsigned SIZE_LOG      = 8,
  parameter int unsigned HOST_MAX_WAIT = 4
) (
  input logic               clk,
  input logic               reset,
  data_ram_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, ACK, CLR_SETUP, CLR_STROBE, CLR_END
  } state_t;

  state_t              r_state, w_state_next;
  logic                r_owner_host, w_owner_next;
  logic                r_is_write, w_write_next;
  logic [3:0]          r_wait, w_wait_next;
  logic [SIZE_LOG-1:0] r_clr_idx, w_idx_next;
  logic [SIZE_LOG-1:0] r_ram_address, w_addr_next;
  logic [WORD-1:0]     r_ram_data_in, w_wdata_next;
  logic [WORD-1:0]     r_cpu_rdata, w_cpu_rdata_next;
  logic [WORD-1:0]     r_host_rdata, w_host_rdata_next;
  logic                r_ram_write, r_ram_reset, r_clear_busy;
  logic                r_cpu_ack, r_host_ack;
  logic                w_in_clear;

  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner_host;
    w_write_next      = r_is_write;
    w_wait_next       = r_wait;
    w_idx_next        = r_clr_idx;
    w_addr_next       = r_ram_address;
    w_wdata_next      = r_ram_data_in;
    w_cpu_rdata_next  = r_cpu_rdata;
    w_host_rdata_next = r_host_rdata;
    unique case (r_state)
      IDLE: begin
        w_idx_next = '0;
        if (!bus.host_req) w_wait_next = '0;
        if (bus.clear_start) begin
          w_state_next = CLR_SETUP;
          w_addr_next  = '0;
        end else if (bus.host_req && (r_wait == MAX_WAIT)) begin
          w_state_next = SETUP;
          w_owner_next = 1'b1;
          w_write_next = bus.host_write;
          w_addr_next  = bus.host_addr;
          w_wdata_next = bus.host_wdata;
          w_wait_next  = '0;
        end else if (bus.cpu_req) begin
          w_state_next = SETUP;
          w_owner_next = 1'b0;
          w_write_next = bus.cpu_write;
          w_addr_next  = bus.cpu_addr;
          w_wdata_next = bus.cpu_wdata;
          if (bus.host_req && (r_wait != MAX_WAIT)) w_wait_next = r_wait + 4'd1;
        end else if (bus.host_req) begin
          w_state_next = SETUP;
          w_owner_next = 1'b1;
          w_write_next = bus.host_write;
          w_addr_next  = bus.host_addr;
          w_wdata_next = bus.host_wdata;
          w_wait_next  = '0;
        end
      end
      SETUP: begin
        if (r_is_write) begin
          w_state_next = STROBE;
        end else begin
          w_state_next = ACK;
          if (r_owner_host) w_host_rdata_next = bus.ram_data_out;
          else              w_cpu_rdata_next  = bus.ram_data_out;
        end
      end
      STROBE:    w_state_next = ACK;
      ACK:       w_state_next = IDLE;
      CLR_SETUP: w_state_next = CLR_STROBE;
      CLR_STROBE: begin
        if (r_clr_idx == '1) begin
          w_state_next = CLR_END;
        end else begin
          w_state_next = CLR_SETUP;
          w_idx_next   = r_clr_idx + 1'b1;
          w_addr_next  = r_clr_idx + 1'b1;
        end
      end
      CLR_END: begin
        w_state_next = IDLE;
        w_idx_next   = '0;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Strobe/reset/ack flags are decoded from the next state so they are registered outputs.
  assign w_in_clear = (w_state_next == CLR_SETUP) || (w_state_next == CLR_STROBE) ||
                      (w_state_next == CLR_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_owner_host  <= 1'b0;
      r_is_write    <= 1'b0;
      r_wait        <= '0;
      r_clr_idx     <= '0;
      r_ram_address <= '0;
      r_ram_data_in <= '0;
      r_cpu_rdata   <= '0;
      r_host_rdata  <= '0;
      r_ram_write   <= 1'b0;
      r_ram_reset   <= 1'b0;
      r_clear_busy  <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_host_ack    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_owner_host  <= w_owner_next;
      r_is_write    <= w_write_next;
      r_wait        <= w_wait_next;
      r_clr_idx     <= w_idx_next;
      r_ram_address <= w_addr_next;
      r_ram_data_in <= w_wdata_next;
      r_cpu_rdata   <= w_cpu_rdata_next;
      r_host_rdata  <= w_host_rdata_next;
      r_ram_write   <= (w_state_next == STROBE) || (w_state_next == CLR_STROBE);
      r_ram_reset   <= w_in_clear;
      r_clear_busy  <= w_in_clear;
      r_cpu_ack     <= (w_state_next == ACK) && !w_owner_next;
      r_host_ack    <= (w_state_next == ACK) && w_owner_next;
    end
  end

  assign bus.ram_write   = r_ram_write;
  assign bus.ram_reset   = r_ram_reset;
  assign bus.ram_address = r_ram_address;
  assign bus.ram_data_in = r_ram_data_in;
  assign bus.cpu_ack     = r_cpu_ack;
  assign bus.cpu_rdata   = r_cpu_rdata;
  assign bus.host_ack    = r_host_ack;
  assign bus.host_rdata  = r_host_rdata;
  assign bus.clear_busy  = r_clear_busy;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a behavioural 256x1 RAM whose
// address 5 reads an external input pin.
module tb_data_ram_arbiter;

  logic clk;
  logic reset;
  logic pin;
  logic mem [0:255];
  int   errors;
  int   checks;

  data_ram_arbiter_if #(.WORD(1), .SIZE_LOG(8)) bus ();

  data_ram_arbiter #(.WORD(1), .SIZE_LOG(8), .HOST_MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge bus.ram_write) begin
    if (bus.ram_reset) mem[bus.ram_address] = 1'b0;
    else               mem[bus.ram_address] = bus.ram_data_in;
  end

  always_comb begin
    if (bus.ram_address == 8'd5) bus.ram_data_out = pin;
    else                         bus.ram_data_out = mem[bus.ram_address];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one CPU access to completion; ok=0 if no ack within the budget.
  task automatic cpu_access(input logic wr, input logic [7:0] a, input logic d,
                            output logic rd, output logic ok);
    ok = 1'b0;
    rd = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_write = wr;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.cpu_ack) begin
        rd = bus.cpu_rdata;
        ok = 1'b1;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step(); step();
    checks++; if (bus.ram_write !== 1'b0)   begin errors++; $display("FAIL reset_ram_write got %b want 0", bus.ram_write); end
    checks++; if (bus.ram_reset !== 1'b0)   begin errors++; $display("FAIL reset_ram_reset got %b want 0", bus.ram_reset); end
    checks++; if (bus.ram_address !== 8'h00) begin errors++; $display("FAIL reset_ram_address got %h want 00", bus.ram_address); end
    checks++; if ({bus.cpu_ack, bus.host_ack, bus.clear_busy} !== 3'b000)
      begin errors++; $display("FAIL reset_flags got %b want 000", {bus.cpu_ack, bus.host_ack, bus.clear_busy}); end
    checks++; if ({bus.cpu_rdata, bus.host_rdata, bus.ram_data_in} !== 3'b000)
      begin errors++; $display("FAIL reset_data got %b want 000", {bus.cpu_rdata, bus.host_rdata, bus.ram_data_in}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_cpu_write_read();
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 8'h20; bus.cpu_wdata = 1'b1;
    step();  // cycle 1: SETUP
    checks++; if ({bus.ram_write, bus.cpu_ack} !== 2'b00) begin errors++; $display("FAIL wr_c1_strobe_ack got %b want 00", {bus.ram_write, bus.cpu_ack}); end
    checks++; if (bus.ram_address !== 8'h20) begin errors++; $display("FAIL wr_c1_addr got %h want 20", bus.ram_address); end
    step();  // cycle 2: STROBE
    checks++; if ({bus.ram_write, bus.ram_data_in, bus.cpu_ack} !== 3'b110) begin errors++; $display("FAIL wr_c2_strobe got %b want 110", {bus.ram_write, bus.ram_data_in, bus.cpu_ack}); end
    step();  // cycle 3: ACK
    checks++; if ({bus.ram_write, bus.cpu_ack, bus.host_ack} !== 3'b010) begin errors++; $display("FAIL wr_c3_ack got %b want 010", {bus.ram_write, bus.cpu_ack, bus.host_ack}); end
    bus.cpu_req = 1'b0;
    step();
    checks++; if ({bus.cpu_ack, mem[8'h20]} !== 2'b01) begin errors++; $display("FAIL wr_c4_mem got %b want 01", {bus.cpu_ack, mem[8'h20]}); end
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 8'h20;
    step();
    checks++; if ({bus.ram_write, bus.cpu_ack} !== 2'b00) begin errors++; $display("FAIL rd_c1 got %b want 00", {bus.ram_write, bus.cpu_ack}); end
    step();
    checks++; if ({bus.ram_write, bus.cpu_ack, bus.cpu_rdata} !== 3'b011) begin errors++; $display("FAIL rd_c2_ack_data got %b want 011", {bus.ram_write, bus.cpu_ack, bus.cpu_rdata}); end
    bus.cpu_req = 1'b0;
    step();
    checks++; if ({bus.cpu_ack, bus.cpu_rdata} !== 2'b01) begin errors++; $display("FAIL rd_hold got %b want 01", {bus.cpu_ack, bus.cpu_rdata}); end
  endtask

  task automatic test_host_pin_read();
    logic saw_wr, saw_cpu;
    saw_wr = 1'b0; saw_cpu = 1'b0;
    pin = 1'b1;
    bus.host_req = 1'b1; bus.host_write = 1'b0; bus.host_addr = 8'd5; bus.host_wdata = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      saw_wr  = saw_wr | bus.ram_write;
      saw_cpu = saw_cpu | bus.cpu_ack;
      if (i == 2) begin
        checks++; if ({bus.host_ack, bus.host_rdata} !== 2'b11) begin errors++; $display("FAIL host_pin_ack_data got %b want 11", {bus.host_ack, bus.host_rdata}); end
        bus.host_req = 1'b0;
      end
    end
    checks++; if ({saw_wr, saw_cpu} !== 2'b00) begin errors++; $display("FAIL host_pin_side_effects got %b want 00", {saw_wr, saw_cpu}); end
    pin = 1'b0;
  endtask

  task automatic test_host_starvation();
    int  n_cpu, round1, round2, hosts, dbl;
    logic prev_cpu, rearm;
    n_cpu = 0; round1 = -1; round2 = -1; hosts = 0; dbl = 0; prev_cpu = 1'b0; rearm = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 8'h20;
    bus.host_req = 1'b1; bus.host_write = 1'b0; bus.host_addr = 8'h20;
    for (int i = 0; i < 80; i++) begin
      step();
      if (rearm) begin bus.host_req = 1'b1; rearm = 1'b0; end
      if (bus.cpu_ack && prev_cpu) dbl++;
      prev_cpu = bus.cpu_ack;
      if (bus.cpu_ack) n_cpu++;
      if (bus.host_ack) begin
        hosts++;
        bus.host_req = 1'b0;
        if (hosts == 1) begin round1 = n_cpu; n_cpu = 0; rearm = 1'b1; end
        else begin round2 = n_cpu; break; end
      end
    end
    bus.cpu_req = 1'b0; bus.host_req = 1'b0;
    step(); step();
    checks++; if (round1 !== 4) begin errors++; $display("FAIL starve_round1 got %0d cpu grants want 4", round1); end
    checks++; if (round2 !== 4) begin errors++; $display("FAIL starve_round2_after_clear got %0d cpu grants want 4", round2); end
    checks++; if (dbl !== 0) begin errors++; $display("FAIL starve_ack_width got %0d double acks want 0", dbl); end
  endtask

  task automatic test_simultaneous();
    int cpu_at, host_at, cpu_hi, host_hi;
    cpu_at = -1; host_at = -1; cpu_hi = 0; host_hi = 0;
    bus.cpu_req  = 1'b1; bus.cpu_write  = 1'b1; bus.cpu_addr  = 8'h40; bus.cpu_wdata  = 1'b1;
    bus.host_req = 1'b1; bus.host_write = 1'b1; bus.host_addr = 8'h41; bus.host_wdata = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus.cpu_ack)  begin cpu_hi++;  if (cpu_at < 0)  cpu_at = i;  bus.cpu_req = 1'b0;  end
      if (bus.host_ack) begin host_hi++; if (host_at < 0) host_at = i; bus.host_req = 1'b0; end
    end
    checks++; if (cpu_at !== 3)  begin errors++; $display("FAIL simul_cpu_ack_cycle got %0d want 3", cpu_at); end
    checks++; if (host_at !== 7) begin errors++; $display("FAIL simul_host_ack_cycle got %0d want 7", host_at); end
    checks++; if ({cpu_hi, host_hi} !== {32'd1, 32'd1}) begin errors++; $display("FAIL simul_ack_widths got %0d/%0d want 1/1", cpu_hi, host_hi); end
    checks++; if ({mem[8'h40], mem[8'h41]} !== 2'b11) begin errors++; $display("FAIL simul_mem got %b want 11", {mem[8'h40], mem[8'h41]}); end
  endtask

  task automatic test_clear();
    logic rd, ok1, ok2, ok3, ok4;
    int   busy_n, strobes, bad;
    busy_n = 0; strobes = 0; bad = 0;
    cpu_access(1'b1, 8'h10, 1'b1, rd, ok1);
    cpu_access(1'b1, 8'hFF, 1'b1, rd, ok2);
    checks++; if ({ok1, ok2, mem[8'h10], mem[8'hFF]} !== 4'b1111) begin errors++; $display("FAIL clr_preload got %b want 1111", {ok1, ok2, mem[8'h10], mem[8'hFF]}); end
    bus.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (!bus.clear_busy) break;
      busy_n++;
      if (bus.ram_write) begin strobes++; if (!bus.ram_reset) bad++; end
      step();
    end
    checks++; if (busy_n !== 513) begin errors++; $display("FAIL clr_busy_cycles got %0d want 513", busy_n); end
    checks++; if ({strobes, bad} !== {32'd256, 32'd0}) begin errors++; $display("FAIL clr_strobes got %0d (%0d without reset) want 256 (0)", strobes, bad); end
    checks++; if (bus.ram_reset !== 1'b0) begin errors++; $display("FAIL clr_reset_release got %b want 0", bus.ram_reset); end
    cpu_access(1'b0, 8'h10, 1'b0, rd, ok3);
    checks++; if ({ok3, rd} !== 2'b10) begin errors++; $display("FAIL clr_read_10 got ok/data %b want 10", {ok3, rd}); end
    cpu_access(1'b0, 8'hFF, 1'b0, rd, ok4);
    checks++; if ({ok4, rd} !== 2'b10) begin errors++; $display("FAIL clr_read_ff got ok/data %b want 10", {ok4, rd}); end
  endtask

  task automatic test_reset_mid_write();
    logic rd, ok1, ok2, saw;
    saw = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 8'h30; bus.cpu_wdata = 1'b1;
    step();  // SETUP
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    step();
    reset = 1'b0;
    checks++; if ({bus.ram_write, bus.cpu_ack, bus.ram_address} !== {2'b00, 8'h00}) begin errors++; $display("FAIL rst_mid_outputs got %b_%h want 00_00", {bus.ram_write, bus.cpu_ack}, bus.ram_address); end
    for (int i = 0; i < 4; i++) begin
      step();
      saw = saw | bus.ram_write | bus.cpu_ack;
    end
    checks++; if ({saw, mem[8'h30]} !== 2'b00) begin errors++; $display("FAIL rst_mid_no_write got %b want 00", {saw, mem[8'h30]}); end
    cpu_access(1'b1, 8'h30, 1'b1, rd, ok1);
    cpu_access(1'b0, 8'h30, 1'b0, rd, ok2);
    checks++; if ({ok1, ok2, rd} !== 3'b111) begin errors++; $display("FAIL rst_mid_fresh_access got %b want 111", {ok1, ok2, rd}); end
  endtask

  initial begin
    errors = 0; checks = 0;
    pin = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 1'b0;
    bus.cpu_req = 1'b0;  bus.cpu_write = 1'b0;  bus.cpu_addr = '0;  bus.cpu_wdata = 1'b0;
    bus.host_req = 1'b0; bus.host_write = 1'b0; bus.host_addr = '0; bus.host_wdata = 1'b0;
    bus.clear_start = 1'b0;
    reset = 1'b1;
    test_reset();
    test_cpu_write_read();
    test_host_pin_read();
    test_host_starvation();
    test_simultaneous();
    test_clear();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
